sdram_if_responder: RTL
=======================

Name: sdram_if_responder

Overview:
- Synthesizable responder for the sdram_top internal request/ack interface (sdram_wr_req/sdram_rd_req, sdram_wr_ack/sdram_rd_ack, sys_wraddr/sys_rdaddr, sdwr_byte/sdrd_byte).
- Backed by on-chip block RAM in place of external SDRAM.
- Lets traffic generators and SDRAM test tops run in simulation and on-board without the SDRAM controller, with the same handshake timing.

Parameters:
- ADDR_W, 24, width of sys_wraddr/sys_rdaddr.
- DATA_W, 16, data word width.
- BURST_W, 10, width of sdwr_byte/sdrd_byte.
- MEM_AW, 11, BRAM word-address width (2048 words).
- INIT_CYCLES, 200, cycles from reset release to sdram_init_done.
- WR_LAT, 4, cycles from accepted write request to first sdram_wr_ack.
- RD_LAT, 6, cycles from accepted read request to first sdram_rd_ack.
- WR_DATA_DLY, 2, cycles after an ack cycle at which the matching sys_data_in word is sampled.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sdram_wr_req  in  1  write burst request, level.
- sdram_rd_req  in  1  read burst request, level.
- sys_wraddr  in  ADDR_W  write start word address.
- sys_rdaddr  in  ADDR_W  read start word address.
- sdwr_byte  in  BURST_W  write burst length in words.
- sdrd_byte  in  BURST_W  read burst length in words.
- sys_data_in  in  DATA_W  write data from initiator.
- sdram_wr_ack  out  1  one cycle per write word.
- sdram_rd_ack  out  1  one cycle per read word; sys_data_out is valid in the same cycle.
- sys_data_out  out  DATA_W  read data.
- sdram_init_done  out  1  responder ready; sticky.
- busy  out  1  a burst is in progress or latency is pending.
- abort_flag  out  1  sticky; set when a request drops mid-burst.

Behaviour:
- Reset values: all outputs 0; state INIT; counters 0. Reset mid-burst aborts immediately; BRAM contents are not cleared.
- INIT: count INIT_CYCLES, then set sdram_init_done and go to IDLE. Requests are ignored before init_done.
- IDLE:
  - wr_req has priority when both requests are high in the same cycle.
  - On the accepted request, latch start address low MEM_AW bits and length, then go to WR_WAIT or RD_WAIT.
  - Length 0: go straight to RELEASE, no acks.
- WR_WAIT: WR_LAT-1 cycles, then WR_BURST.
- WR_BURST:
  - sdram_wr_ack is high for exactly len consecutive cycles.
  - For ack cycle k (k=0..len-1), sys_data_in is sampled WR_DATA_DLY cycles later and written to addr=(start+k) mod 2^MEM_AW.
  - A delay shift register carries ack and address so writes drain after the burst ends.
- RD_WAIT: RD_LAT-1 cycles, then RD_BURST.
  - The BRAM read for word 0 is issued in the last wait cycle, so data aligns with ack.
- RD_BURST:
  - sdram_rd_ack is high for exactly len consecutive cycles; sys_data_out = mem[(start+k) mod 2^MEM_AW] in ack cycle k.
  - sys_data_out holds its last value when ack is low.
- RELEASE: wait until the serviced request is low. A request still held high after its burst never re-triggers; a new burst needs a low cycle first.
- Request dropping in WR_WAIT/WR_BURST/RD_WAIT/RD_BURST:
  - Stop acks the next cycle and set abort_flag.
  - Pending delayed write samples still complete.
  - Go to IDLE.
- Address wrap: the burst crosses 2^MEM_AW modulo; upper address bits are ignored.
- Read-after-write: a read issued while write drain is non-empty stalls in RD_WAIT until drain is empty, then waits the full RD_LAT.
- busy = state not in {INIT, IDLE} or write drain non-empty.
- Latency counters are width clog2(max(WR_LAT,RD_LAT)+1); the burst counter is BURST_W bits.

Decomposition:
- Package sdram_if_pkg holds the state encodings (INIT, IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST, RELEASE) and default widths (ADDR_W, DATA_W, BURST_W).
- One sub-module, sdram_if_bram: single-clock simple dual-port RAM, DATA_W x 2^MEM_AW, registered read, 1-cycle latency.

Test Plan:
- Reset release, hold wr_req=1 -> sdram_init_done rises at cycle 200, no wr_ack before it; first wr_ack 4 cycles after init_done.
- Write 512 words at address 0x000200 with sys_data_in advancing on delayed ack, then read 512 -> exactly 512 rd_acks; sys_data_out equals 0..511 in order; abort_flag stays 0.
- Write 8 words at address 0x0007FC -> words land at 0x7FC..0x7FF and 0x000..0x003; read back over the same range matches.
- wr_req and rd_req high in the same cycle -> write serviced first; read starts only after wr_req low and drain empty, with a full 6-cycle RD_LAT.
- Drop rd_req after 3 of 16 acks -> ack low next cycle, abort_flag=1 sticky, state IDLE; the next request services normally.
- sdwr_byte=0 with wr_req high -> no wr_ack, busy is 1 until wr_req drops; holding a request high after burst completion -> no second burst.

Source files
------------

// File: rtl/sdram_if_pkg.sv
// Shared state encoding and default interface widths for the BRAM-backed
// SDRAM request/ack responder.
package sdram_if_pkg;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 10;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_WAIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    RELEASE
  } state_t;

endpackage

// File: rtl/sdram_if_bram.sv
// Single-clock simple dual-port RAM: one write port, one registered read
// port with 1-cycle latency. The read register holds when re is low, so
// the read data stays stable between bursts.
module sdram_if_bram #(
  parameter int DATA_W = 16,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; only the output register is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdram_if_responder.sv
// Stand-in for the SDRAM controller's internal request/ack interface,
// backed by on-chip BRAM, reproducing the controller's handshake timing.
//
// Handshake: the initiator raises *_req and holds it for the whole burst.
// The responder accepts a request only in IDLE, answers with one *_ack
// cycle per word after a fixed latency, and then waits in RELEASE until
// that request is seen low; a request held high never starts a second
// burst. Dropping the request before the last ack aborts the burst.
// Write data for ack k is sampled WR_DATA_DLY cycles after that ack.
// Read data is valid in the same cycle as its rd_ack. WR_LAT/RD_LAT >= 2.
module sdram_if_responder #(
  parameter int ADDR_W      = sdram_if_pkg::ADDR_W,
  parameter int DATA_W      = sdram_if_pkg::DATA_W,
  parameter int BURST_W     = sdram_if_pkg::BURST_W,
  parameter int MEM_AW      = 11,
  parameter int INIT_CYCLES = 200,
  parameter int WR_LAT      = 4,
  parameter int RD_LAT      = 6,
  parameter int WR_DATA_DLY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdram_wr_req,
  input  logic               sdram_rd_req,
  input  logic [ADDR_W-1:0]  sys_wraddr,
  input  logic [ADDR_W-1:0]  sys_rdaddr,
  input  logic [BURST_W-1:0] sdwr_byte,
  input  logic [BURST_W-1:0] sdrd_byte,
  input  logic [DATA_W-1:0]  sys_data_in,
  output logic               sdram_wr_ack,
  output logic               sdram_rd_ack,
  output logic [DATA_W-1:0]  sys_data_out,
  output logic               sdram_init_done,
  output logic               busy,
  output logic               abort_flag
);
  import sdram_if_pkg::*;

  localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);
  localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [LAT_W-1:0]   WR_LAST   = LAT_W'(WR_LAT - 2);
  localparam logic [LAT_W-1:0]   RD_LAST   = LAT_W'(RD_LAT - 2);
  localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
  localparam logic [BURST_W-1:0] BEAT_ONE  = BURST_W'(1);
  localparam logic [MEM_AW-1:0]  ADDR_ONE  = MEM_AW'(1);

  state_t              state, state_nxt;
  logic [INIT_W-1:0]   init_cnt;
  logic [LAT_W-1:0]    lat_cnt, lat_nxt;
  logic [BURST_W-1:0]  beat_cnt, beat_nxt, len_r, len_nxt;
  logic [MEM_AW-1:0]   start_r, start_nxt;
  logic                svc_wr, svc_wr_nxt;
  logic                abort_r, abort_nxt;
  logic                init_done_r;
  logic                wr_ack_c, rd_ack_c, rd_en;
  logic [MEM_AW-1:0]   rd_addr, wr_addr_c;
  logic [WR_DATA_DLY-1:0] dly_vld;
  logic [MEM_AW-1:0]   dly_addr [WR_DATA_DLY];
  logic                drain_busy;
  logic                addr_unused;

  // Only the low MEM_AW address bits select a BRAM word.
  assign addr_unused = ^{sys_wraddr[ADDR_W-1:MEM_AW], sys_rdaddr[ADDR_W-1:MEM_AW]};
  assign drain_busy  = |dly_vld;
  assign wr_addr_c   = start_r + MEM_AW'(beat_cnt);

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done_r <= 1'b0;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      len_r       <= '0;
      start_r     <= '0;
      svc_wr      <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      beat_cnt <= beat_nxt;
      len_r    <= len_nxt;
      start_r  <= start_nxt;
      svc_wr   <= svc_wr_nxt;
      abort_r  <= abort_nxt;
      if (state == INIT) init_cnt <= init_cnt + INIT_W'(1);
      if (state == INIT && init_cnt == INIT_LAST) init_done_r <= 1'b1;
    end
  end

  // Next-state, acks and BRAM read issue.
  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    beat_nxt   = beat_cnt;
    len_nxt    = len_r;
    start_nxt  = start_r;
    svc_wr_nxt = svc_wr;
    abort_nxt  = abort_r;
    wr_ack_c   = 1'b0;
    rd_ack_c   = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = start_r + MEM_AW'(beat_cnt) + ADDR_ONE;
    case (state)
      INIT: if (init_cnt == INIT_LAST) state_nxt = IDLE;
      IDLE: begin
        lat_nxt  = '0;
        beat_nxt = '0;
        if (sdram_wr_req) begin
          start_nxt  = sys_wraddr[MEM_AW-1:0];
          len_nxt    = sdwr_byte;
          svc_wr_nxt = 1'b1;
          state_nxt  = (sdwr_byte == '0) ? RELEASE : WR_WAIT;
        end else if (sdram_rd_req) begin
          start_nxt  = sys_rdaddr[MEM_AW-1:0];
          len_nxt    = sdrd_byte;
          svc_wr_nxt = 1'b0;
          state_nxt  = (sdrd_byte == '0) ? RELEASE : RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (!sdram_wr_req) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (lat_cnt == WR_LAST) state_nxt = WR_BURST;
        else lat_nxt = lat_cnt + LAT_ONE;
      end
      WR_BURST: begin
        wr_ack_c = 1'b1;
        // Completing the last word wins over a request dropped in that cycle.
        if (beat_cnt == len_r - BEAT_ONE) state_nxt = RELEASE;
        else if (!sdram_wr_req) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else beat_nxt = beat_cnt + BEAT_ONE;
      end
      RD_WAIT: begin
        if (!sdram_rd_req) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (drain_busy) lat_nxt = '0;
        else if (lat_cnt == RD_LAST) begin
          // Issue word 0 now so its data lands with the first ack.
          rd_en     = 1'b1;
          rd_addr   = start_r;
          state_nxt = RD_BURST;
        end else lat_nxt = lat_cnt + LAT_ONE;
      end
      RD_BURST: begin
        rd_ack_c = 1'b1;
        if (beat_cnt == len_r - BEAT_ONE) state_nxt = RELEASE;
        else if (!sdram_rd_req) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          beat_nxt = beat_cnt + BEAT_ONE;
          rd_en    = 1'b1;
        end
      end
      RELEASE: if (svc_wr ? !sdram_wr_req : !sdram_rd_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write drain: carries each ack and its address until its data is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld <= '0;
      for (int i = 0; i < WR_DATA_DLY; i++) dly_addr[i] <= '0;
    end else begin
      for (int i = WR_DATA_DLY - 1; i > 0; i--) begin
        dly_vld[i]  <= dly_vld[i-1];
        dly_addr[i] <= dly_addr[i-1];
      end
      dly_vld[0]  <= wr_ack_c;
      dly_addr[0] <= wr_addr_c;
    end
  end

  sdram_if_bram #(.DATA_W(DATA_W), .AW(MEM_AW)) u_bram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (dly_vld[WR_DATA_DLY-1]),
    .waddr (dly_addr[WR_DATA_DLY-1]),
    .wdata (sys_data_in),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (sys_data_out)
  );

  assign sdram_wr_ack    = wr_ack_c;
  assign sdram_rd_ack    = rd_ack_c;
  assign sdram_init_done = init_done_r;
  assign abort_flag      = abort_r;
  assign busy            = (state != INIT && state != IDLE) || drain_busy;

endmodule
